// File: rtl/demux_1n_stripe.sv
// demux_1n_stripe: 1:N round-robin byte-striping demux with one registered cycle of latency.
// Define DEMUX_LANE_CNT_EN to add per-lane 16-bit valid-word counters on lane_cnt.
module demux_1n_stripe #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int ADV_MODE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      align,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_valid,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] sel,
  output logic                      stripe_done
`ifdef DEMUX_LANE_CNT_EN
  ,
  output logic [LANES*16-1:0]       lane_cnt
`endif
);

  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [SW-1:0] LAST       = SW'(LANES - 1);
  localparam logic [SW-1:0] ONE        = SW'(1);
  localparam logic [SW-1:0] ALIGN_NEXT = (LANES > 1) ? SW'(1) : '0;

  logic [LANES*DATA_W-1:0] laneData_q, laneData_d;
  logic [LANES-1:0]        laneValid_q, laneValid_d;
  logic [SW-1:0]           selPtr_q, selPtr_d;
  logic                    stripeDone_q, stripeDone_d;
  logic [SW-1:0]           target;
  logic                    doWrite;
  logic [DATA_W-1:0]       writeWord;

  // Mode 0 writes the target lane every cycle (zero when idle); mode 1 only on valid words.
  always_comb begin
    target      = align ? '0 : selPtr_q;
    doWrite     = in_valid || (ADV_MODE == 0);
    writeWord   = in_valid ? in_data : '0;
    laneData_d  = laneData_q;
    laneValid_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (target == SW'(i)) begin
        if (doWrite) laneData_d[i*DATA_W +: DATA_W] = writeWord;
        laneValid_d[i] = in_valid;
      end
    end
    stripeDone_d = in_valid && (target == LAST);
    if (align)
      selPtr_d = in_valid ? ALIGN_NEXT : '0;
    else if (in_valid || (ADV_MODE == 0))
      selPtr_d = (selPtr_q == LAST) ? '0 : selPtr_q + ONE;
    else
      selPtr_d = selPtr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      laneData_q   <= '0;
      laneValid_q  <= '0;
      selPtr_q     <= '0;
      stripeDone_q <= 1'b0;
    end else begin
      laneData_q   <= laneData_d;
      laneValid_q  <= laneValid_d;
      selPtr_q     <= selPtr_d;
      stripeDone_q <= stripeDone_d;
    end
  end

  assign out_data    = laneData_q;
  assign out_valid   = laneValid_q;
  assign sel         = selPtr_q;
  assign stripe_done = stripeDone_q;

`ifdef DEMUX_LANE_CNT_EN
  logic [LANES*16-1:0] laneCnt_q, laneCnt_d;

  // Counters step alongside the out_valid pulse of the same write.
  always_comb begin
    laneCnt_d = laneCnt_q;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid && (target == SW'(i)))
        laneCnt_d[i*16 +: 16] = laneCnt_q[i*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) laneCnt_q <= '0;
    else       laneCnt_q <= laneCnt_d;
  end

  assign lane_cnt = laneCnt_q;
`endif

endmodule

// File: tb/tb_demux_1n_stripe.sv
// tb_demux_1n_stripe: scoreboard bench for a LANES=4/mode-1 and a LANES=3/mode-0 demux
// driven by the same inputs and checked against a queue-based reference model.
module tb_demux_1n_stripe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inData = 8'h00;
  logic        inValid = 1'b0;
  logic        alignIn = 1'b0;

  logic [31:0] outData0;
  logic [3:0]  outValid0;
  logic [1:0]  sel0;
  logic        done0;
  logic [23:0] outData1;
  logic [2:0]  outValid1;
  logic [1:0]  sel1;
  logic        done1;
`ifdef DEMUX_LANE_CNT_EN
  logic [63:0] cnt0;
  logic [47:0] cnt1;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  valid;
    int           sel;
    bit           done;
    logic [255:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] mLane[2][16];
  bit         mValid[2][16];
  int         mSel[2];
  bit         mDone[2];
  int         mCnt[2][16];

  always #5 clk = ~clk;

  demux_1n_stripe #(.DATA_W(8), .LANES(4), .ADV_MODE(1)) dut0 (
    .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid), .align(alignIn),
    .out_data(outData0), .out_valid(outValid0), .sel(sel0), .stripe_done(done0)
`ifdef DEMUX_LANE_CNT_EN
    , .lane_cnt(cnt0)
`endif
  );

  demux_1n_stripe #(.DATA_W(8), .LANES(3), .ADV_MODE(0)) dut1 (
    .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid), .align(alignIn),
    .out_data(outData1), .out_valid(outValid1), .sel(sel1), .stripe_done(done1)
`ifdef DEMUX_LANE_CNT_EN
    , .lane_cnt(cnt1)
`endif
  );

  // Reference model: lanes as an array, pointer advanced with modulo arithmetic.
  task automatic modelStep(input int k, input int lanes, input int mode);
    int tgt;
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mLane[k][i] = 8'h00; mValid[k][i] = 0; mCnt[k][i] = 0;
      end
      mSel[k] = 0; mDone[k] = 0;
    end else begin
      tgt = alignIn ? 0 : mSel[k];
      for (int i = 0; i < 16; i++) mValid[k][i] = 0;
      mDone[k] = 0;
      if (inValid) begin
        mLane[k][tgt] = inData;
        mValid[k][tgt] = 1;
        mCnt[k][tgt] = (mCnt[k][tgt] + 1) % 65536;
        mDone[k] = (tgt == lanes - 1);
      end else if (mode == 0) begin
        mLane[k][tgt] = 8'h00;
      end
      if (alignIn) mSel[k] = inValid ? (1 % lanes) : 0;
      else if (mode == 0 || inValid) mSel[k] = (mSel[k] + 1) % lanes;
    end
  endtask

  function automatic exp_t snapshot(input int k, input int lanes);
    exp_t e;
    e.data = '0; e.valid = '0; e.cnt = '0;
    for (int i = 0; i < lanes; i++) begin
      e.data[i*8 +: 8]   = mLane[k][i];
      e.valid[i]         = mValid[k][i];
      e.cnt[i*16 +: 16]  = 16'(mCnt[k][i]);
    end
    e.sel  = mSel[k];
    e.done = mDone[k];
    return e;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d, input bit al);
    reset = r; inValid = v; inData = d; alignIn = al;
    @(posedge clk);
    modelStep(0, 4, 1);
    modelStep(1, 3, 0);
    q0.push_back(snapshot(0, 4));
    q1.push_back(snapshot(1, 3));
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected snapshot per cycle the driver has issued and compares.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checkOutput("l4m1_data",  256'(outData0),  256'(e.data[31:0]));
      checkOutput("l4m1_valid", 256'(outValid0), 256'(e.valid[3:0]));
      checkOutput("l4m1_sel",   256'(sel0),      256'(e.sel));
      checkOutput("l4m1_done",  256'(done0),     256'(e.done));
`ifdef DEMUX_LANE_CNT_EN
      checkOutput("l4m1_cnt",   256'(cnt0),      256'(e.cnt[63:0]));
`endif
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput("l3m0_data",  256'(outData1),  256'(e.data[23:0]));
      checkOutput("l3m0_valid", 256'(outValid1), 256'(e.valid[2:0]));
      checkOutput("l3m0_sel",   256'(sel1),      256'(e.sel));
      checkOutput("l3m0_done",  256'(done1),     256'(e.done));
`ifdef DEMUX_LANE_CNT_EN
      checkOutput("l3m0_cnt",   256'(cnt1),      256'(e.cnt[47:0]));
`endif
    end
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset held two cycles while a valid word is presented.
    applyStimulus(1, 1, 8'hAA, 0);
    applyStimulus(1, 1, 8'hAA, 0);
    // Full stripe back-to-back.
    applyStimulus(0, 1, 8'h11, 0);
    applyStimulus(0, 1, 8'h22, 0);
    applyStimulus(0, 1, 8'h33, 0);
    applyStimulus(0, 1, 8'h44, 0);
    applyStimulus(0, 0, 8'h00, 0);
    // Gaps between valid words.
    applyStimulus(0, 1, 8'h55, 0);
    applyStimulus(0, 0, 8'hEE, 0);
    applyStimulus(0, 0, 8'hEE, 0);
    applyStimulus(0, 1, 8'h66, 0);
    // Realign with a valid word, then with an idle cycle.
    applyStimulus(0, 1, 8'h77, 1);
    applyStimulus(0, 1, 8'h78, 0);
    applyStimulus(0, 0, 8'h00, 1);
    // Alternating valid/invalid for six cycles.
    for (int i = 0; i < 6; i++) applyStimulus(0, (i % 2) == 0, 8'(8'h80 + i), 0);
    // Reset mid-stripe after lane 1 is written.
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h91, 0);
    applyStimulus(0, 1, 8'h92, 0);
    applyStimulus(1, 1, 8'h93, 0);
    applyStimulus(0, 1, 8'h99, 0);
    applyStimulus(0, 0, 8'h00, 0);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                    8'($urandom), ($urandom_range(0, 9) == 0));
    end
    applyStimulus(0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
